// File: rtl/syn_pcm_fetch_ctrl_if.sv
// Sample stream from the PCM fetch controller to its consumer.
// Transfer happens when smpl_valid and smpl_ready are both high.
interface syn_pcm_fetch_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();
  logic              smpl_valid;
  logic [DATA_W-1:0] smpl_data;
  logic [ADDR_W-1:0] smpl_idx;
  logic              smpl_ready;

  modport master (
    output smpl_valid,
    output smpl_data,
    output smpl_idx,
    input  smpl_ready
  );

  modport slave (
    input  smpl_valid,
    input  smpl_data,
    input  smpl_idx,
    output smpl_ready
  );
endinterface

// File: rtl/syn_pcm_fetch_ctrl.sv
// PCM frame fetch controller: reads one frame from the PCM buffer
// on a pcm_data_rdy edge and streams it through a small FIFO.
module syn_pcm_fetch_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int NUM_SAMPLES = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              fetch_en,
  input  logic              pcm_data_rdy,
  output logic [ADDR_W-1:0] pcm_addr,
  output logic              pcm_rden,
  input  logic [DATA_W-1:0] pcm_rdata,
  input  logic              pcm_rd_valid,
  syn_pcm_fetch_ctrl_if.master smpl,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              ovrn_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic              rdy_q, rdy_qq;
  logic [1:0]        arm;
  logic              rdy_edge, start;
  logic [CW-1:0]     inflight, count;
  logic [CW:0]       occ_sum;
  logic              room, last_rd;
  logic              rd_ok, push, pop, last_xfer;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  // arm delays edge detection until rdy_qq holds a real sample,
  // so a level already high at reset release is not an edge
  assign rdy_edge = rdy_q & ~rdy_qq & arm[1] & fetch_en;
  assign start    = rdy_edge && (state == IDLE);
  assign ovrn_err = rdy_edge && (state != IDLE);

  assign occ_sum = {1'b0, inflight} + {1'b0, count};
  assign room    = occ_sum < (CW+1)'(FIFO_DEPTH);
  assign last_rd = pcm_rden &&
                   (pcm_addr == ADDR_W'(NUM_SAMPLES-1));

  assign rd_ok = pcm_rd_valid && (inflight != '0);
  assign pop   = smpl.smpl_valid && smpl.smpl_ready;
  assign push  = rd_ok &&
                 ((count != CW'(FIFO_DEPTH)) || pop);

  assign last_xfer  = pop && (idx == ADDR_W'(NUM_SAMPLES-1));
  assign fetch_done = last_xfer && (state == DRAIN);
  assign fetch_busy = (state != IDLE);

  assign smpl.smpl_valid = (count != '0);
  assign smpl.smpl_data  = smpl.smpl_valid ? mem[rd_ptr] : '0;
  assign smpl.smpl_idx   = idx;

  always_comb begin
    state_nx = state;
    pcm_rden = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: begin
        pcm_rden = room;
        if (last_rd) state_nx = DRAIN;
      end
      DRAIN: if (last_xfer) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state  <= IDLE;
      rdy_q  <= 1'b0;
      rdy_qq <= 1'b0;
      arm    <= '0;
    end else begin
      state  <= state_nx;
      rdy_q  <= pcm_data_rdy;
      rdy_qq <= rdy_q;
      arm    <= {arm[0], 1'b1};
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pcm_addr <= '0;
      inflight <= '0;
      idx      <= '0;
    end else begin
      if (start)         pcm_addr <= '0;
      else if (pcm_rden) pcm_addr <= pcm_addr + 1'b1;
      if (pcm_rden && !rd_ok)      inflight <= inflight + 1'b1;
      else if (!pcm_rden && rd_ok) inflight <= inflight - 1'b1;
      if (start || fetch_done) idx <= '0;
      else if (pop)            idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_ir) begin
    if (push) mem[wr_ptr] <= pcm_rdata;
  end
endmodule

// File: tb/tb_syn_pcm_fetch_ctrl.sv
// Scoreboard bench for syn_pcm_fetch_ctrl with a 2-cycle PCM
// buffer model; stimulus queues expectations, a monitor checks.
module tb_syn_pcm_fetch_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 256;
  localparam int FD = 4;

  logic          clk_ir = 1'b0;
  logic          rst_il = 1'b0;
  logic          fetch_en = 1'b0;
  logic          pcm_data_rdy = 1'b0;
  logic [AW-1:0] pcm_addr;
  logic          pcm_rden;
  logic [DW-1:0] pcm_rdata;
  logic          pcm_rd_valid;
  logic          fetch_busy, fetch_done, ovrn_err;

  syn_pcm_fetch_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) smpl ();

  syn_pcm_fetch_ctrl #(
    .DATA_W(DW), .ADDR_W(AW),
    .NUM_SAMPLES(N), .FIFO_DEPTH(FD)
  ) dut (
    .clk_ir(clk_ir), .rst_il(rst_il),
    .fetch_en(fetch_en), .pcm_data_rdy(pcm_data_rdy),
    .pcm_addr(pcm_addr), .pcm_rden(pcm_rden),
    .pcm_rdata(pcm_rdata), .pcm_rd_valid(pcm_rd_valid),
    .smpl(smpl),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .ovrn_err(ovrn_err)
  );

  always #5 clk_ir = ~clk_ir;

  function automatic logic [DW-1:0] mem_val(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  // PCM buffer model: data returns two cycles after the strobe
  logic          p1 = 1'b0, p2 = 1'b0, inj = 1'b0;
  logic [AW-1:0] a1 = '0, a2 = '0;
  always @(posedge clk_ir) begin
    p1 <= pcm_rden;
    a1 <= pcm_addr;
    p2 <= p1;
    a2 <= a1;
  end
  assign pcm_rd_valid = p2 | inj;
  assign pcm_rdata    = mem_val(int'(a2));

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int rd_cnt = 0, xfer_cnt = 0;
  int done_cnt = 0, ovrn_cnt = 0;
  int rise_cyc = 0, first_rd_cyc = 0, done_cyc = 0;
  logic [AW-1:0] exp_addr = '0;
  bit done_prev = 1'b0;

  always @(posedge clk_ir) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_ir) begin
    exp_t e;
    if (rst_il) begin
      if (done_prev) chk("busy_after_done", fetch_busy, 0);
      done_prev = fetch_done;
      if (pcm_rden) begin
        if (rd_cnt == 0) first_rd_cyc = cyc;
        chk("rd_addr", pcm_addr, exp_addr);
        chk("rd_in_frame", rd_cnt < N, 1);
        chk("rd_no_overflow", (rd_cnt - xfer_cnt) < FD, 1);
        exp_addr++;
        rd_cnt++;
      end
      if (fetch_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_on_last",
            smpl.smpl_valid && smpl.smpl_ready &&
            smpl.smpl_idx == AW'(N-1), 1);
      end
      if (smpl.smpl_valid && smpl.smpl_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("smpl_idx", smpl.smpl_idx, e.idx);
          chk("smpl_data", smpl.smpl_data, e.data);
        end
        xfer_cnt++;
      end
      if (ovrn_err) ovrn_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_ir);
    #1;
  endtask

  task automatic start_frame();
    pcm_data_rdy = 1'b0;
    step(3);
    exp_addr = '0;
    rd_cnt   = 0;
    xfer_cnt = 0;
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.idx  = AW'(i);
      e.data = mem_val(i);
      sb.push_back(e);
    end
    pcm_data_rdy = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      step(1);
      t++;
    end
    chk("frame_done", done_cnt, target);
  endtask

  task automatic wait_xfer(input int n, input int budget);
    int t = 0;
    while (xfer_cnt < n && t < budget) begin
      step(1);
      t++;
    end
    chk("xfer_reached", xfer_cnt >= n, 1);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_rden"}, pcm_rden, 0);
    chk({nm, "_addr"}, pcm_addr, 0);
    chk({nm, "_valid"}, smpl.smpl_valid, 0);
    chk({nm, "_data"}, smpl.smpl_data, 0);
    chk({nm, "_idx"}, smpl.smpl_idx, 0);
    chk({nm, "_busy"}, fetch_busy, 0);
    chk({nm, "_done"}, fetch_done, 0);
    chk({nm, "_ovrn"}, ovrn_err, 0);
  endtask

  initial begin
    int ov0, dn0;
    smpl.smpl_ready = 1'b1;
    step(3);
    chk_quiet("rst");
    rst_il   = 1'b1;
    fetch_en = 1'b1;
    step(3);

    // full frame, consumer always ready
    start_frame();
    wait_done(1, 400);
    chk("a_latency", first_rd_cyc - rise_cyc, 2);
    chk("a_frame_len", done_cyc - rise_cyc, 260);
    step(5);
    chk("a_reads", rd_cnt, N);
    chk("a_xfers", xfer_cnt, N);
    chk("a_sb_empty", sb.size(), 0);

    // consumer stalled: only FIFO_DEPTH reads may issue
    smpl.smpl_ready = 1'b0;
    start_frame();
    step(22);
    chk("b_reads", rd_cnt, FD);
    chk("b_valid", smpl.smpl_valid, 1);
    chk("b_head", smpl.smpl_data, mem_val(0));
    chk("b_idx", smpl.smpl_idx, 0);
    smpl.smpl_ready = 1'b1;
    wait_done(2, 400);
    chk("b_xfers", xfer_cnt, N);
    chk("b_sb_empty", sb.size(), 0);

    // random backpressure
    start_frame();
    begin
      int t = 0;
      while (done_cnt < 3 && t < 3000) begin
        smpl.smpl_ready = 1'($urandom_range(0, 1));
        step(1);
        t++;
      end
    end
    smpl.smpl_ready = 1'b1;
    chk("c_done", done_cnt, 3);
    chk("c_xfers", xfer_cnt, N);
    chk("c_sb_empty", sb.size(), 0);

    // second edge mid-frame is an overrun, frame continues
    start_frame();
    step(5);
    pcm_data_rdy = 1'b0;
    wait_xfer(100, 400);
    pcm_data_rdy = 1'b1;
    wait_done(4, 400);
    chk("d_ovrn", ovrn_cnt, 1);
    chk("d_xfers", xfer_cnt, N);
    step(10);
    chk("d_no_restart", fetch_busy, 0);
    chk("d_reads", rd_cnt, N);

    // reset mid-frame with pcm_data_rdy held high
    start_frame();
    wait_xfer(50, 400);
    rst_il = 1'b0;
    step(2);
    chk_quiet("e_rst");
    sb.delete();
    rd_cnt   = 0;
    xfer_cnt = 0;
    ov0 = ovrn_cnt;
    dn0 = done_cnt;
    rst_il = 1'b1;
    step(20);
    chk_quiet("e_post");
    chk("e_reads", rd_cnt, 0);
    chk("e_ovrn", ovrn_cnt, ov0);
    start_frame();
    wait_done(dn0 + 1, 400);
    chk("e_xfers", xfer_cnt, N);
    chk("e_sb_empty", sb.size(), 0);

    // fetch disabled: edge ignored; stray valid ignored
    fetch_en = 1'b0;
    pcm_data_rdy = 1'b0;
    rd_cnt   = 0;
    xfer_cnt = 0;
    ov0 = ovrn_cnt;
    step(3);
    pcm_data_rdy = 1'b1;
    step(10);
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    step(5);
    chk("f_reads", rd_cnt, 0);
    chk("f_busy", fetch_busy, 0);
    chk("f_ovrn", ovrn_cnt, ov0);
    chk("f_valid", smpl.smpl_valid, 0);
    chk("f_xfers", xfer_cnt, 0);
    fetch_en = 1'b1;
    step(5);
    chk("f_late_en", fetch_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/syn_pcm_fetch_ctrl.md
SYN_PCM_FETCH_CTRL -- requirements
Module: syn_pcm_fetch_ctrl

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, PCM sample word width.
REQ-002 SHALL have parameter ADDR_W, default 8, PCM buffer address width.
REQ-003 SHALL have parameter NUM_SAMPLES, default 256, samples per frame; legal range 2..2^ADDR_W.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth; power of 2, at least 2.

Interface
REQ-005 SHALL have port clk_ir, input, 1 bit: single clock; one clock domain; all logic on its rising edge.
REQ-006 SHALL have port rst_il, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port fetch_en, input, 1 bit: enables frame fetch; while low, rising edges of pcm_data_rdy are ignored.
REQ-008 SHALL have port pcm_data_rdy, input, 1 bit: level from Acortex; high means a complete frame is available.
REQ-009 SHALL have port pcm_addr, output, ADDR_W bits: PCM buffer read address.
REQ-010 SHALL have port pcm_rden, output, 1 bit: read strobe, one read per cycle.
REQ-011 SHALL have port pcm_rdata, input, DATA_W bits: read data.
REQ-012 SHALL have port pcm_rd_valid, input, 1 bit: qualifies pcm_rdata; arrives a fixed number of cycles after pcm_rden.
REQ-013 SHALL have port smpl_valid, output, 1 bit: sample available to the downstream consumer.
REQ-014 SHALL have port smpl_data, output, DATA_W bits: sample value.
REQ-015 SHALL have port smpl_idx, output, ADDR_W bits: sample index within the frame, 0..NUM_SAMPLES-1.
REQ-016 SHALL have port smpl_ready, input, 1 bit: consumer accepts the sample; transfer occurs when smpl_valid and smpl_ready are both high.
REQ-017 SHALL have port fetch_busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port fetch_done, output, 1 bit: one-cycle pulse on the transfer of the last sample.
REQ-019 SHALL have port ovrn_err, output, 1 bit: one-cycle pulse when a new frame is detected while fetch_busy is high.

Function
REQ-020 Frame start detection: pcm_data_rdy SHALL be registered, and a start SHALL be a 0->1 transition seen while fetch_en=1.
REQ-021 The FSM SHALL have exactly three states: IDLE, FETCH and DRAIN.
REQ-022 IDLE->FETCH SHALL occur on a start; the read address counter and issued count SHALL clear to 0 on this transition.
REQ-023 In FETCH, pcm_rden SHALL assert only when (reads in flight + FIFO occupancy) < FIFO_DEPTH, so the FIFO can never overflow.
REQ-024 Each pcm_rden SHALL present the current address, and the address SHALL then increment by 1.
REQ-025 FETCH->DRAIN SHALL occur in the cycle the NUM_SAMPLES-th read is issued; no further pcm_rden SHALL follow it.
REQ-026 Reads in flight: counter SHALL be +1 on pcm_rden, -1 on pcm_rd_valid, unchanged when both occur in the same cycle; its width SHALL hold FIFO_DEPTH.
REQ-027 On pcm_rd_valid, pcm_rdata SHALL be pushed into the FIFO.
REQ-028 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-029 smpl_valid SHALL equal FIFO not-empty.
REQ-030 smpl_data SHALL be the FIFO head, held stable while smpl_valid=1 and smpl_ready=0.
REQ-031 smpl_idx SHALL start at 0 per frame and increment on each transfer.
REQ-032 DRAIN->IDLE SHALL occur on the transfer with smpl_idx=NUM_SAMPLES-1, and fetch_done SHALL pulse in that same cycle.
REQ-033 A start detected while busy SHALL be dropped: ovrn_err pulses and the current frame continues unaffected.
REQ-034 fetch_en deasserted mid-frame SHALL NOT abort the frame.
REQ-035 An unsolicited pcm_rd_valid (in-flight counter 0) SHALL be ignored; no push and no counter underflow.
REQ-036 Read latency: first pcm_rden SHALL assert 2 cycles after pcm_data_rdy rises (1 cycle edge register, 1 cycle state change).

Reset
REQ-037 On rst_il low, the following SHALL clear asynchronously: state to IDLE; pcm_addr=0, pcm_rden=0; smpl_valid=0, smpl_data=0, smpl_idx=0; fetch_busy=0, fetch_done=0, ovrn_err=0; FIFO pointers and all counters to 0; the registered pcm_data_rdy to 0.
REQ-038 Reset asserted mid-frame SHALL discard all data in flight and in the FIFO.
REQ-039 After reset release, a pcm_data_rdy already high SHALL NOT start a frame; a new 0->1 edge is required.

Verification (defaults, read latency 2)
REQ-040 fetch_en=1, pcm_data_rdy 0->1, smpl_ready=1 -> pcm_addr sweeps 0..255, one per cycle once the pipeline fills; 256 transfers with smpl_idx 0..255 and data matching the memory model; fetch_done pulses once; no pcm_rden after address 255.
REQ-041 smpl_ready=0 for 20 cycles after start -> exactly 4 reads issued, then pcm_rden stays low; FIFO holds samples 0..3; on smpl_ready=1 the stream resumes in order with no loss or duplicate.
REQ-042 Random smpl_ready (50%) over a full frame -> FIFO never overflows; output order and data are correct; fetch_busy falls the cycle after fetch_done.
REQ-043 Second pcm_data_rdy edge at sample 100 of an active frame -> ovrn_err pulses once; the frame completes 256 samples; no restart occurs.
REQ-044 Reset pulse at sample 50, then pcm_data_rdy held high -> all outputs 0, state IDLE, no fetch; a subsequent 0->1 edge -> fresh frame starting at address 0 with smpl_idx 0.
REQ-045 fetch_en=0 with a pcm_data_rdy edge -> no pcm_rden, fetch_busy stays 0, ovrn_err stays 0.
